// File: rtl/signed_divider_seq.sv
// Sequential signed divider using sign/magnitude split and a restoring shift-subtract loop.
// Optional macro DIV_SPECIAL_BYPASS_EN: divide-by-zero and overflow skip the loop (1-edge latency).
module signed_divider_seq #(
  parameter int l = 16
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         Start,
  input  logic [l-1:0] Dividend,
  input  logic [l-1:0] Divisor,
  output logic         Ready,
  output logic         Done,
  output logic [l-1:0] Quotient,
  output logic [l-1:0] Remainder,
  output logic         DivByZero,
  output logic         Overflow
);

  localparam int lv = l - 1;
  localparam int CW = $clog2(l) + 1;
  localparam logic [CW-1:0] LAST = CW'(l - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [l-1:0] ONE = {{(l-1){1'b0}}, 1'b1};
  localparam logic [l-1:0] MIN_VAL = {1'b1, {(l-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t state, next_state;

  logic          quot_sign, rem_sign;
  logic          dbz_pend, ovf_pend;
  logic [l-1:0]  q_reg, dvs_abs, dvd_save;
  // Partial remainder is held in l bits: after every step it is below |Divisor|, which fits in l bits.
  logic [l-1:0]  part_rem;
  logic [CW-1:0] count;

  logic          div_zero_in, ovf_in;
  logic [l:0]    shifted;
  logic [l-1:0]  step_p, step_q;

  function automatic logic [l-1:0] negate(input logic [l-1:0] x);
    return (~x) + ONE;
  endfunction

  function automatic logic [l-1:0] magnitude(input logic [l-1:0] x);
    return x[lv] ? negate(x) : x;
  endfunction

  assign div_zero_in = (Divisor == '0);
  assign ovf_in      = (Dividend == MIN_VAL) && (Divisor == '1);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (Start) begin
`ifdef DIV_SPECIAL_BYPASS_EN
        next_state = (div_zero_in || ovf_in) ? SIGN : CALC;
`else
        next_state = CALC;
`endif
      end
      CALC:    if (count == LAST) next_state = SIGN;
      SIGN:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    Ready = (state == IDLE);
  end

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    shifted = {part_rem, q_reg[lv]};
    step_p  = shifted[l-1:0];
    step_q  = {q_reg[lv-1:0], 1'b0};
    if (shifted >= {1'b0, dvs_abs}) begin
      step_p = l'(shifted - {1'b0, dvs_abs});
      step_q = {q_reg[lv-1:0], 1'b1};
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      quot_sign <= 1'b0;
      rem_sign  <= 1'b0;
      dbz_pend  <= 1'b0;
      ovf_pend  <= 1'b0;
      q_reg     <= '0;
      dvs_abs   <= '0;
      dvd_save  <= '0;
      part_rem  <= '0;
      count     <= '0;
      Done      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          quot_sign <= Dividend[lv] ^ Divisor[lv];
          rem_sign  <= Dividend[lv];
          q_reg     <= magnitude(Dividend);
          dvs_abs   <= magnitude(Divisor);
          dvd_save  <= Dividend;
          part_rem  <= '0;
          count     <= '0;
          dbz_pend  <= div_zero_in;
          ovf_pend  <= ovf_in;
        end
        CALC: begin
          q_reg    <= step_q;
          part_rem <= step_p;
          count    <= count + CNT_ONE;
        end
        SIGN: begin
          Done <= 1'b1;
          if (dbz_pend) begin
            Quotient  <= '1;
            Remainder <= dvd_save;
            DivByZero <= 1'b1;
            Overflow  <= 1'b0;
          end else if (ovf_pend) begin
            Quotient  <= MIN_VAL;
            Remainder <= '0;
            DivByZero <= 1'b0;
            Overflow  <= 1'b1;
          end else begin
            Quotient  <= quot_sign ? negate(q_reg) : q_reg;
            Remainder <= rem_sign ? negate(part_rem) : part_rem;
            DivByZero <= 1'b0;
            Overflow  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider_seq.sv
// Self-checking bench for signed_divider_seq: directed corner cases plus randomized runs vs an integer model.
module tb_signed_divider_seq;
  localparam int L = 16;
`ifdef DIV_SPECIAL_BYPASS_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = L + 1;
`endif
  localparam logic [L-1:0] MIN_VAL = {1'b1, {(L-1){1'b0}}};

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start;
  logic [L-1:0] dividend, divisor;
  logic         ready, done;
  logic [L-1:0] quotient, remainder;
  logic         div_by_zero, overflow;

  int tests_run = 0;
  int tests_failed = 0;

  signed_divider_seq #(.l(L)) dut (
    .Clock(clock), .ResetN(reset_n), .Start(start),
    .Dividend(dividend), .Divisor(divisor),
    .Ready(ready), .Done(done),
    .Quotient(quotient), .Remainder(remainder),
    .DivByZero(div_by_zero), .Overflow(overflow)
  );

  always #5 clock = ~clock;

  // Expected {Q, R, DivByZero, Overflow} from plain integer division (truncating, remainder follows dividend).
  function automatic logic [2*L+1:0] ref_div(input logic [L-1:0] a, input logic [L-1:0] b);
    int ai, bi;
    logic [L-1:0] q, r;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0)                       return {{L{1'b1}}, a, 2'b10};
    if (ai == -(1 << (L-1)) && bi == -1) return {MIN_VAL, {L{1'b0}}, 2'b01};
    q = L'(ai / bi);
    r = L'(ai % bi);
    return {q, r, 2'b00};
  endfunction

  function automatic logic [2*L+1:0] observed();
    return {quotient, remainder, div_by_zero, overflow};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clock);
      n++;
    end
  endtask

  // Drive Start at a negedge; returns at the negedge following the accept edge.
  task automatic start_div(input logic [L-1:0] a, input logic [L-1:0] b);
    wait_ready();
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clock);
      edges++;
      @(negedge clock);
    end while (!done && edges < 100);
    if (!done) edges = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; dividend = 16'h1234; divisor = 16'h0003;
    repeat (3) @(negedge clock);
    tests_run++;
    if ({ready, done, observed()} !== {2'b10, {(2*L+2){1'b0}}}) begin
      tests_failed++;
      $display("FAIL reset_state: got %h expected %h", {ready, done, observed()}, {2'b10, {(2*L+2){1'b0}}});
    end
    start = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    int e;
    start_div(16'd100, 16'd7);
    wait_done(e);
    tests_run++;
    if (e !== L + 1) begin
      tests_failed++; $display("FAIL basic_latency: got %0d expected %0d", e, L + 1);
    end
    tests_run++;
    if (observed() !== {16'd14, 16'd2, 2'b00}) begin
      tests_failed++; $display("FAIL basic_result: got %h expected %h", observed(), {16'd14, 16'd2, 2'b00});
    end
    @(posedge clock); @(negedge clock);
    tests_run++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      tests_failed++; $display("FAIL done_pulse: got done=%b ready=%b expected done=0 ready=1", done, ready);
    end
  endtask

  task automatic test_signs();
    logic [L-1:0] ops [3][2] = '{'{16'hFFF9, 16'h0002}, '{16'h0007, 16'hFFFE}, '{16'hFFF9, 16'hFFFE}};
    logic [2*L+1:0] want [3] = '{{16'hFFFD, 16'hFFFF, 2'b00}, {16'hFFFD, 16'h0001, 2'b00},
                                  {16'h0003, 16'hFFFF, 2'b00}};
    int e;
    for (int i = 0; i < 3; i++) begin
      start_div(ops[i][0], ops[i][1]);
      wait_done(e);
      tests_run++;
      if (observed() !== want[i] || e !== L + 1) begin
        tests_failed++;
        $display("FAIL signs_%0d: got %h after %0d edges expected %h after %0d", i, observed(), e, want[i], L + 1);
      end
    end
  endtask

  task automatic test_special();
    int e;
    start_div(MIN_VAL, 16'hFFFF);
    wait_done(e);
    tests_run++;
    if (observed() !== {MIN_VAL, 16'h0000, 2'b01} || e !== SPECIAL_LAT) begin
      tests_failed++;
      $display("FAIL overflow: got %h after %0d edges expected %h after %0d", observed(), e, {MIN_VAL, 16'h0000, 2'b01}, SPECIAL_LAT);
    end
    start_div(16'h1234, 16'h0000);
    wait_done(e);
    tests_run++;
    if (observed() !== {16'hFFFF, 16'h1234, 2'b10} || e !== SPECIAL_LAT) begin
      tests_failed++;
      $display("FAIL div_by_zero: got %h after %0d edges expected %h after %0d", observed(), e, {16'hFFFF, 16'h1234, 2'b10}, SPECIAL_LAT);
    end
  endtask

  task automatic test_ignore_start();
    int e = 0;
    start_div(16'd1000, 16'hFFF3);
    do begin
      @(posedge clock);
      e++;
      @(negedge clock);
      // A stray Start sampled at edge 5 must be ignored while busy.
      if (e == 4) begin start = 1'b1; dividend = 16'd5; divisor = 16'd1; end
      if (e == 5) start = 1'b0;
    end while (!done && e < 100);
    tests_run++;
    if (!done || e !== L + 1 || observed() !== ref_div(16'd1000, 16'hFFF3)) begin
      tests_failed++;
      $display("FAIL ignore_start: got %h after %0d edges expected %h after %0d", observed(), e, ref_div(16'd1000, 16'hFFF3), L + 1);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    bit held_ok = 1'b1;
    logic [2*L+1:0] first = ref_div(16'd30000, 16'd123);
    start_div(16'd30000, 16'd123);
    wait_done(e);
    tests_run++;
    if (observed() !== first) begin
      tests_failed++; $display("FAIL b2b_first: got %h expected %h", observed(), first);
    end
    start = 1'b1; dividend = 16'hD8F1; divisor = 16'd17;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    e = 0;
    do begin
      if (!done && observed() !== first) held_ok = 1'b0;
      @(posedge clock);
      e++;
      @(negedge clock);
    end while (!done && e < 100);
    tests_run++;
    if (!held_ok) begin
      tests_failed++; $display("FAIL b2b_hold: got held=%b expected held=1", held_ok);
    end
    tests_run++;
    if (!done || e !== L + 1 || observed() !== ref_div(16'hD8F1, 16'd17)) begin
      tests_failed++;
      $display("FAIL b2b_second: got %h after %0d edges expected %h after %0d", observed(), e, ref_div(16'hD8F1, 16'd17), L + 1);
    end
  endtask

  task automatic test_reset_abort();
    int e;
    bit saw_done = 1'b0;
    start_div(16'd12345, 16'd77);
    repeat (8) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({ready, done, observed()} !== {2'b10, {(2*L+2){1'b0}}}) begin
      tests_failed++;
      $display("FAIL abort_reset: got %h expected %h", {ready, done, observed()}, {2'b10, {(2*L+2){1'b0}}});
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (25) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
    end
    tests_run++;
    if (saw_done) begin
      tests_failed++; $display("FAIL abort_no_done: got done pulse expected none");
    end
    start_div(16'd9, 16'd3);
    wait_done(e);
    tests_run++;
    if (observed() !== {16'd3, 16'd0, 2'b00} || e !== L + 1) begin
      tests_failed++;
      $display("FAIL abort_rerun: got %h after %0d edges expected %h after %0d", observed(), e, {16'd3, 16'd0, 2'b00}, L + 1);
    end
  endtask

  task automatic test_random();
    logic [L-1:0] a, b;
    logic [2*L+1:0] want;
    int e, lat;
    for (int i = 0; i < 40; i++) begin
      a = L'($urandom);
      b = L'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = MIN_VAL; b = '1; end
        2: b = L'($urandom_range(0, 16)) - L'(8);
        default: ;
      endcase
      want = ref_div(a, b);
      lat = (want[1] || want[0]) ? SPECIAL_LAT : L + 1;
      start_div(a, b);
      wait_done(e);
      tests_run++;
      if (observed() !== want || e !== lat) begin
        tests_failed++;
        $display("FAIL random_%0d (%h/%h): got %h after %0d edges expected %h after %0d", i, a, b, observed(), e, want, lat);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_special();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
